// File: rtl/ltc2344_responder.sv
// LTC2344-style quad-channel ADC responder: cnv/busy conversion, 4-lane SDO readout.
// Define LTC2344_RESPONDER_SPAN_EN to enable SDI softspan capture and channel disable.
module ltc2344_responder #(
  parameter int          CONV_CYCLES  = 16,
  parameter logic [11:0] DEFAULT_SPAN = 12'hFFF
) (
  input  logic        serialClock,
  input  logic        reset,
  input  logic        cnv,
  input  logic        CS,
  input  logic        SDI,
  input  logic [15:0] chanData0,
  input  logic [15:0] chanData1,
  input  logic [15:0] chanData2,
  input  logic [15:0] chanData3,
  output logic        busy,
  output logic [3:0]  SDO,
  output logic [11:0] activeSpan,
  output logic        spanValid,
  output logic [7:0]  convCount
);

`ifdef LTC2344_RESPONDER_SPAN_EN
  localparam bit SpanEn = 1'b1;
`else
  localparam bit SpanEn = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    WAIT_CS,
    SHIFT
  } state_t;

  state_t      state_q, state_n;
  logic        cnv_q;
  logic [7:0]  cnt_q, cnt_n;
  logic        busy_n;
  logic [15:0] sr_q [4];
  logic [15:0] sr_n [4];
  logic [15:0] chan [4];
  logic [3:0]  bit_q, bit_n;
  logic [7:0]  cc_n;
  logic [11:0] sdi_q, sdi_n;
  logic [11:0] cap_q, cap_n;
  logic [11:0] span_n;
  logic        sv_n;

  assign chan[0] = chanData0;
  assign chan[1] = chanData1;
  assign chan[2] = chanData2;
  assign chan[3] = chanData3;

  assign SDO = (state_q == WAIT_CS || state_q == SHIFT)
             ? {sr_q[3][15], sr_q[2][15], sr_q[1][15], sr_q[0][15]}
             : 4'b0000;

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    busy_n  = busy;
    sr_n    = sr_q;
    bit_n   = bit_q;
    cc_n    = convCount;
    sdi_n   = sdi_q;
    cap_n   = cap_q;
    span_n  = activeSpan;
    sv_n    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cnv && !cnv_q) begin
          state_n = CONVERT;
          busy_n  = 1'b1;
          cnt_n   = 8'(CONV_CYCLES);
          if (SpanEn) span_n = cap_q;
          // masking uses the span being applied to this conversion
          for (int i = 0; i < 4; i++) begin
            if (SpanEn && cap_q[3*i +: 3] == 3'b000) sr_n[i] = 16'h0000;
            else sr_n[i] = chan[i];
          end
        end
      end
      CONVERT: begin
        if (cnt_q == 8'd1) begin
          busy_n  = 1'b0;
          state_n = WAIT_CS;
        end else begin
          cnt_n = cnt_q - 8'd1;
        end
      end
      WAIT_CS: begin
        if (!CS) begin
          for (int i = 0; i < 4; i++) sr_n[i] = {sr_q[i][14:0], 1'b0};
          bit_n   = 4'd1;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (CS) begin
          state_n = IDLE;
          bit_n   = 4'd0;
        end else begin
          for (int i = 0; i < 4; i++) sr_n[i] = {sr_q[i][14:0], 1'b0};
          bit_n = bit_q + 4'd1;
          if (SpanEn && bit_q >= 4'd1 && bit_q <= 4'd12) begin
            sdi_n = {sdi_q[10:0], SDI};
            if (bit_q == 4'd12) begin
              cap_n = {sdi_q[10:0], SDI};
              sv_n  = 1'b1;
            end
          end
          if (bit_q == 4'd15) begin
            cc_n    = convCount + 8'd1;
            state_n = IDLE;
            bit_n   = 4'd0;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge serialClock) begin
    if (reset) begin
      state_q    <= IDLE;
      cnv_q      <= 1'b1;
      cnt_q      <= 8'd0;
      busy       <= 1'b0;
      sr_q       <= '{default: 16'h0000};
      bit_q      <= 4'd0;
      convCount  <= 8'd0;
      sdi_q      <= DEFAULT_SPAN;
      cap_q      <= DEFAULT_SPAN;
      activeSpan <= DEFAULT_SPAN;
      spanValid  <= 1'b0;
    end else begin
      state_q    <= state_n;
      cnv_q      <= cnv;
      cnt_q      <= cnt_n;
      busy       <= busy_n;
      sr_q       <= sr_n;
      bit_q      <= bit_n;
      convCount  <= cc_n;
      sdi_q      <= sdi_n;
      cap_q      <= cap_n;
      activeSpan <= span_n;
      spanValid  <= sv_n;
    end
  end

endmodule

// File: doc/ltc2344_responder.md
LTC2344_RESPONDER -- requirements
Module: ltc2344_responder

Interface
REQ-001 SHALL have parameter CONV_CYCLES, default 16, busy-high duration in serialClock cycles; legal range 2..255.
REQ-002 SHALL have parameter DEFAULT_SPAN, default 12'hFFF, softspan word in force after reset.
REQ-003 SHALL have port serialClock, input, 1, sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port cnv, input, 1, conversion start from the controller.
REQ-006 SHALL have port CS, input, 1, active-low chip select; shifting occurs only while low.
REQ-007 SHALL have port SDI, input, 1, serial softspan word from the controller, MSB first.
REQ-008 SHALL have port chanData0..chanData3, input, 16 each, sample values converted on the cnv rising edge.
REQ-009 SHALL have port busy, output, 1, conversion in progress.
REQ-010 SHALL have port SDO, output, 4, one serial data lane per channel (SDO[i] carries channel i), MSB first.
REQ-011 SHALL have port activeSpan, output, 12, softspan word applied to the current conversion.
REQ-012 SHALL have port spanValid, output, 1, one-cycle pulse when a complete 12-bit SDI word is captured.
REQ-013 SHALL have port convCount, output, 8, count of completed 16-bit readouts; wraps 255 -> 0.

Function
REQ-014 SHALL implement states IDLE, CONVERT, WAIT_CS, SHIFT.
REQ-015 IDLE: cnv sampled high with previous-cycle cnv low SHALL latch chanData0..3 into four 16-bit shift registers, set busy=1, load the cycle counter with CONV_CYCLES, go to CONVERT.
REQ-016 CONVERT: SHALL decrement the counter each cycle; when it reaches 1, SHALL set busy=0 on that edge and go to WAIT_CS; busy high for exactly CONV_CYCLES cycles.
REQ-017 cnv edges in CONVERT, WAIT_CS or SHIFT SHALL be ignored; a cnv held high SHALL NOT retrigger.
REQ-018 SDO[i] SHALL equal the MSB of shift register i in WAIT_CS and SHIFT, and 0 in IDLE and CONVERT.
REQ-019 WAIT_CS: the first edge with CS low SHALL shift all four registers left by one (zero fill), set bitCnt=1, enter SHIFT; the controller samples bit 15 on that edge.
REQ-020 SHIFT: each edge with CS low SHALL shift once and increment bitCnt; the edge with bitCnt=15 completes the 16th shift, SHALL increment convCount and return to IDLE.
REQ-021 SHIFT: on edges with bitCnt 1..12, SDI SHALL be shifted into a 12-bit capture register LSB-in; at bitCnt=12, spanValid SHALL pulse the following cycle.
REQ-022 Captured span SHALL load into activeSpan at the next accepted cnv edge, never mid-conversion.
REQ-023 CS high during SHIFT SHALL abort: return to IDLE, discard the partial SDI word, leave convCount and activeSpan unchanged, no spanValid.
REQ-024 CS high in WAIT_CS SHALL hold state with data retained; a new cnv edge in WAIT_CS SHALL be ignored until readout completes.
REQ-025 CS low in IDLE or CONVERT SHALL have no effect.

Reset
REQ-026 reset SHALL force IDLE, busy=0, SDO=4'b0000, activeSpan=DEFAULT_SPAN, capture register=DEFAULT_SPAN, spanValid=0, convCount=0, bitCnt=0, shift registers=0.
REQ-027 reset SHALL take priority over all other inputs, including mid-CONVERT and mid-SHIFT; the first post-reset cnv rising edge SHALL require cnv sampled low after reset release.

Configuration
REQ-028 Macro LTC2344_RESPONDER_SPAN_EN defined: channel i with activeSpan[3i+2:3i]==3'b000 SHALL latch 16'h0000 instead of chanDatai (channel disabled).
REQ-029 Macro not defined: SDI SHALL be ignored, activeSpan SHALL stay DEFAULT_SPAN, spanValid SHALL stay 0, all channels latch chanData.

Verification
REQ-030 CONV_CYCLES=16, chanData0..3=16'hA5C3,16'h1234,16'hFFFF,16'h0001, cnv pulse, CS low 16 cycles after busy falls -> busy high exactly 16 cycles; SDO lanes deliver the four words MSB first; convCount=1.
REQ-031 Macro defined, SDI word 12'b000000111111 during readout, second conversion -> spanValid single pulse; activeSpan=12'h03F after second cnv; SDO[3:2] all zeros, SDO[1:0] carry data.
REQ-032 CS driven high after 8 bits -> IDLE, convCount unchanged, no spanValid; next conversion reads full fresh words.
REQ-033 reset asserted mid-CONVERT (cycle 5) -> busy=0, SDO=0 next edge, activeSpan=12'hFFF, cnv held high through release does not start a conversion.
REQ-034 cnv toggled during CONVERT and during SHIFT -> no restart, busy width unchanged, data unchanged.
REQ-035 256 complete readouts -> convCount wraps to 0.
